// File: rtl/uart_deserialized_pkg.sv
// rtl/uart_deserialized_pkg.sv - shared UART frame constants, defaults and receiver state encoding
package uart_deserialized_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  localparam int DEF_CLKS_PER_BIT     = 173;
  localparam int DEF_DATA_WIDTH_BYTES = 6;
  localparam int DEF_TIMEOUT_BITS     = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Bits needed to hold every value 0..max_val without overflow
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver on an already-synchronized line
module uart_rx_byte
  import uart_deserialized_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] byte_out,
  output logic                      byte_valid,
  output logic                      frame_err,
  output logic                      idle
);

  localparam int CLK_W = cnt_width(CLKS_PER_BIT - 1);
  localparam int BIT_W = cnt_width(UART_DATA_BITS - 1);
  localparam logic [CLK_W-1:0] HALF_BIT = CLK_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CLK_W-1:0] FULL_BIT = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  rx_state_t                 r_state;
  logic [CLK_W-1:0]          r_clk_cnt;
  logic [BIT_W-1:0]          r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_byte_out;
  logic                      r_byte_valid;
  logic                      r_frame_err;

  // Frame state machine: mid-bit sampling, LSB first, registered result strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (!rx) r_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == HALF_BIT) begin
            r_clk_cnt <= '0;
            // a line already back high at mid start bit was only a glitch
            r_state   <= rx ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == FULL_BIT) begin
            r_clk_cnt <= '0;
            r_shift   <= {rx, r_shift[UART_DATA_BITS-1:1]};
            if (r_bit_idx == LAST_BIT) r_state <= RX_STOP;
            else r_bit_idx <= r_bit_idx + BIT_W'(1);
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == FULL_BIT) begin
            r_clk_cnt <= '0;
            if (rx) begin
              r_byte_out   <= r_shift;
              r_byte_valid <= 1'b1;
              r_state      <= RX_IDLE;
            end else begin
              r_frame_err  <= 1'b1;
              r_state      <= RX_WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rx) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;
  assign idle       = (r_state == RX_IDLE);

endmodule

// File: rtl/uart_deserialized.sv
// rtl/uart_deserialized.sv - UART receiver assembling multi-byte words with inter-byte timeout
module uart_deserialized
  import uart_deserialized_pkg::*;
#(
  parameter int CLKS_PER_BIT     = DEF_CLKS_PER_BIT,
  parameter int DATA_WIDTH_BYTES = DEF_DATA_WIDTH_BYTES,
  parameter int TIMEOUT_BITS     = DEF_TIMEOUT_BITS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 rx_in,
  output logic [DATA_WIDTH_BYTES*UART_DATA_BITS-1:0] data_out,
  output logic                                 data_valid,
  output logic                                 framing_error,
  output logic                                 timeout_error,
  output logic                                 busy
);

  localparam int WORD_W  = DATA_WIDTH_BYTES * UART_DATA_BITS;
  localparam int PART_W  = (DATA_WIDTH_BYTES - 1) * UART_DATA_BITS;
  localparam int GAP_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = cnt_width(GAP_MAX);
  localparam int BC_W    = cnt_width(DATA_WIDTH_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MAX);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(DATA_WIDTH_BYTES - 1);

  logic [1:0]                r_sync;
  logic [BC_W-1:0]           r_byte_cnt;
  logic [GAP_W-1:0]          r_gap_cnt;
  logic [PART_W-1:0]         r_partial;
  logic [WORD_W-1:0]         r_data_out;
  logic                      r_timeout;

  logic [UART_DATA_BITS-1:0] w_byte;
  logic                      w_byte_valid;
  logic                      w_frame_err;
  logic                      w_rx_idle;
  logic                      w_word_done;
  logic                      w_timeout_hit;
  logic [WORD_W-1:0]         w_word;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx_in};
  end

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst_n     (reset),
    .rx        (r_sync[1]),
    .byte_out  (w_byte),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err),
    .idle      (w_rx_idle)
  );

  assign w_word_done   = w_byte_valid && (r_byte_cnt == LAST_BYTE);
  assign w_timeout_hit = w_rx_idle && (r_byte_cnt != '0) && (r_gap_cnt == GAP_LIMIT);
  assign w_word        = {w_byte, r_partial};

  // Word assembly, byte counter and inter-byte gap timer; timeout wins over everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_partial  <= '0;
      r_data_out <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_timeout_hit) begin
        r_timeout  <= 1'b1;
        r_byte_cnt <= '0;
        r_gap_cnt  <= '0;
      end else begin
        if (w_rx_idle && (r_byte_cnt != '0)) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        else                                 r_gap_cnt <= '0;
        if (w_frame_err) begin
          r_byte_cnt <= '0;
        end else if (w_word_done) begin
          r_byte_cnt <= '0;
          r_data_out <= w_word;
        end else if (w_byte_valid) begin
          r_byte_cnt <= r_byte_cnt + BC_W'(1);
          for (int k = 0; k < DATA_WIDTH_BYTES - 1; k++) begin
            if (r_byte_cnt == BC_W'(k)) r_partial[k*UART_DATA_BITS +: UART_DATA_BITS] <= w_byte;
          end
        end
      end
    end
  end

  // The completed word is presented in the same cycle as its strobe, then held
  assign data_out      = w_word_done ? w_word : r_data_out;
  assign data_valid    = w_word_done;
  assign framing_error = w_frame_err;
  assign timeout_error = r_timeout;
  assign busy          = !w_rx_idle || (r_byte_cnt != '0);

endmodule

// File: tb/tb_uart_deserialized.sv
// tb/tb_uart_deserialized.sv - directed scoreboard bench for uart_deserialized
module tb_uart_deserialized;

  localparam int CPB = 173;
  localparam int NB  = 6;
  localparam int TOB = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            rx_in = 1'b1;
  logic [NB*8-1:0] data_out;
  logic            data_valid;
  logic            framing_error;
  logic            timeout_error;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int n_frm    = 0;
  int n_tmo    = 0;
  logic in_last_stop = 1'b0;
  logic [NB*8-1:0] exp_q[$];
  logic [NB*8-1:0] last_word = '0;

  always #25 clk = ~clk;

  uart_deserialized #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH_BYTES(NB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .timeout_error(timeout_error),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: count error pulses, pop scoreboard on every data_valid
  always @(negedge clk) begin
    if (framing_error === 1'b1) n_frm++;
    if (timeout_error === 1'b1) n_tmo++;
    if (data_valid === 1'b1) begin
      check("valid_during_last_stop", {63'd0, in_last_stop}, 64'd1);
      check("valid_has_pending_word", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        last_word = exp_q.pop_front();
        check("word_data", {16'd0, data_out}, {16'd0, last_word});
      end
    end
  end

  task automatic bit_period(input logic v);
    rx_in = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic last);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    in_last_stop = last;
    bit_period(stop);
    in_last_stop = 1'b0;
    rx_in = 1'b1;
  endtask

  task automatic send_word(input logic [NB*8-1:0] w);
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) exp_q.push_back(w);
      send_byte(w[k*8 +: 8], 1'b1, k == NB - 1);
    end
  endtask

  initial begin
    // reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_data_out", {16'd0, data_out}, 64'd0);
    check("rst_flags", {60'd0, data_valid, framing_error, timeout_error, busy}, 64'd0);
    reset = 1'b1;
    idle_bits(2);

    // two back-to-back words
    send_word(48'hEF0504030201);
    send_word(48'hFF0908070605);
    idle_bits(1);
    check("b2b_drained", exp_q.size(), 64'd0);
    check("b2b_hold", {16'd0, data_out}, 64'h0000FF0908070605);
    check("b2b_no_errors", n_frm + n_tmo, 64'd0);

    // bad stop bit on byte 3, then a clean word
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    idle_bits(2);
    check("frm_count", n_frm, 64'd1);
    check("frm_busy", {63'd0, busy}, 64'd0);
    check("frm_hold", {16'd0, data_out}, 64'h0000FF0908070605);
    send_word(48'h665544332211);
    idle_bits(1);
    check("frm_recover_drained", exp_q.size(), 64'd0);

    // short low glitch on idle line
    rx_in = 1'b0;
    repeat (40) @(posedge clk);
    rx_in = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("glitch_busy", {63'd0, busy}, 64'd0);
    check("glitch_no_events", n_frm + n_tmo, 64'd1);
    check("glitch_hold", {16'd0, data_out}, 64'h0000665544332211);

    // three bytes then a long gap
    send_byte(8'hA1, 1'b1, 1'b0);
    send_byte(8'hA2, 1'b1, 1'b0);
    send_byte(8'hA3, 1'b1, 1'b0);
    #1;
    check("tmo_busy_partial", {63'd0, busy}, 64'd1);
    idle_bits(20);
    #1;
    check("tmo_count", n_tmo, 64'd1);
    check("tmo_busy_cleared", {63'd0, busy}, 64'd0);
    send_word(48'hC6C5C4C3C2C1);
    idle_bits(1);
    check("tmo_recover_drained", exp_q.size(), 64'd0);

    // reset in the middle of byte 4
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'h5B, 1'b1, 1'b0);
    send_byte(8'h5C, 1'b1, 1'b0);
    rx_in = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("mid_byte_busy", {63'd0, busy}, 64'd1);
    #5;
    reset = 1'b0;
    #1;
    check("async_rst_data_out", {16'd0, data_out}, 64'd0);
    check("async_rst_flags", {60'd0, data_valid, framing_error, timeout_error, busy}, 64'd0);
    rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #7;
    reset = 1'b1;
    idle_bits(2);
    send_word(48'h0D0C0B0A0908);
    idle_bits(1);
    check("post_rst_drained", exp_q.size(), 64'd0);
    check("post_rst_hold", {16'd0, data_out}, 64'h00000D0C0B0A0908);
    check("final_error_counts", {n_frm[31:0], n_tmo[31:0]}, {32'd1, 32'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_deserialized.md
UART_DESERIALIZED -- requirements
Module: uart_deserialized

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 173, meaning clk cycles per UART bit period (8N1 framing).
REQ-002 SHALL have parameter DATA_WIDTH_BYTES, default 6, meaning bytes assembled per output word.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 16, meaning maximum idle gap, in bit periods, allowed between bytes of one word.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rises on posedge clk.
REQ-005 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 SHALL have port rx_in, input, 1 bit: asynchronous UART line, idle high.
REQ-007 SHALL have port data_out, output, DATA_WIDTH_BYTES*8 bits: last completed word.
REQ-008 SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-009 SHALL have port framing_error, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port timeout_error, output, 1 bit: one-cycle pulse when a partial word is discarded by timeout.
REQ-011 SHALL have port busy, output, 1 bit: high while a byte is in flight or a partial word is held.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-013 The byte receiver SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 In IDLE, a low synchronized line SHALL move the receiver to START with the bit counter cleared.
REQ-015 START SHALL wait (CLKS_PER_BIT-1)/2 cycles, then resample; if low, go to DATA; if high, treat it as a glitch and return to IDLE with no output.
REQ-016 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-017 STOP SHALL sample CLKS_PER_BIT cycles after the last data bit.
REQ-018 If the stop bit is high, the byte SHALL be accepted and the receiver SHALL return to IDLE.
REQ-019 If the stop bit is low, framing_error SHALL pulse, the byte and any partial word SHALL be discarded, and the receiver SHALL go to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL return to IDLE only once the line is high.
REQ-021 The first accepted byte of a word SHALL land in data_out bits [7:0], and byte k SHALL land in bits [8k+7:8k].
REQ-022 A byte counter SHALL count 0..DATA_WIDTH_BYTES-1 and wrap to 0 after the last byte.
REQ-023 On acceptance of the last byte, data_out SHALL update and data_valid SHALL pulse on the cycle after the stop-bit sample (latency 1 cycle).
REQ-024 data_out SHALL hold its value until the next complete word; partial words SHALL never reach data_out.
REQ-025 While the byte counter is nonzero and the receiver is in IDLE, a gap counter SHALL run.
REQ-026 When the gap counter reaches TIMEOUT_BITS*CLKS_PER_BIT, timeout_error SHALL pulse and the byte counter SHALL clear.
REQ-027 The gap counter SHALL clear on leaving IDLE.
REQ-028 If a timeout and a start detection occur on the same cycle, the timeout SHALL take precedence, and the new byte SHALL start a fresh word.
REQ-029 Back-to-back words with zero idle between the stop bit and the next start bit SHALL be received without loss.
REQ-030 All counters SHALL be sized by $clog2 of their maximum value; there SHALL be no arithmetic overflow.

Reset
REQ-031 Asserting reset SHALL immediately force the following values: state IDLE, all counters 0, data_out 0, and data_valid, framing_error, timeout_error and busy all 0.
REQ-032 Synchronizer flops SHALL reset to 1 (line idle).
REQ-033 Reset asserted mid-byte or mid-word SHALL discard all partial data.
REQ-034 After release, a word SHALL be received starting from the next start bit.

Structure
REQ-035 A shared package SHALL hold the byte receiver state encoding, the UART frame constants (8 data bits, 1 stop bit) and the default parameter values shared with uart_serialized.
REQ-036 Byte reception SHALL be a sub-module uart_rx_byte with outputs byte_out, byte_valid and frame_err.
REQ-037 uart_deserialized SHALL contain the synchronizer, word assembly and timeout logic.

Verification (clk 50 ns, CLKS_PER_BIT 173, DATA_WIDTH_BYTES 6)
REQ-038 Bytes 01,02,03,04,05,EF SHALL produce data_out=48'hEF0504030201 with exactly one data_valid pulse, 1 cycle after the 6th stop-bit sample.
REQ-039 That word followed immediately by bytes 05,06,07,08,09,FF SHALL produce a second pulse with data_out=48'hFF0908070605.
REQ-040 A low stop bit on byte 3 SHALL produce one framing_error pulse and no data_valid; a following clean 6-byte word SHALL be received correctly.
REQ-041 A 40-cycle low glitch on an idle line SHALL produce no outputs, and busy SHALL return to 0.
REQ-042 Three bytes followed by 20 idle bit periods SHALL produce one timeout_error pulse; the next 6 bytes SHALL form a correct word.
REQ-043 Reset asserted during byte 4 SHALL return all outputs to 0; a full word after release SHALL be received correctly.
